// File: rtl/cdc_fifo.sv
// Dual-pointer FIFO with Gray-coded pointers crossing between the write and
// read domains through multi-flop synchronizer chains. Full/empty assert
// immediately from the local pointer and deassert pessimistically once the
// remote pointer has been synchronized.
module cdc_fifo #(
  parameter int unsigned Size       = 16,
  parameter int unsigned Width      = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic             read_clk_i,
  input  logic             read_rst_i,
  input  logic             write_clk_i,
  input  logic             write_rst_i,
  input  logic             write_req_i,
  output logic             write_valid_o,
  input  logic             read_req_i,
  output logic             read_valid_o,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  localparam int unsigned AddrW = $clog2(Size);
  localparam int unsigned PtrW  = AddrW + 1;
  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (PtrW - 2);

  function automatic logic [PtrW-1:0] bin2gray(input logic [PtrW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  logic [Width-1:0] mem_q [Size];

  // Write domain state
  logic [PtrW-1:0]                  wbin_q, wbin_d;
  logic [PtrW-1:0]                  wgray_q, wgray_d;
  logic [SyncStages-1:0][PtrW-1:0]  rsync_q, rsync_d;
  logic                             push;

  // Read domain state
  logic [PtrW-1:0]                  rbin_q, rbin_d;
  logic [PtrW-1:0]                  rgray_q, rgray_d;
  logic [SyncStages-1:0][PtrW-1:0]  wsync_q, wsync_d;
  logic [Width-1:0]                 data_q, data_d;
  logic                             pop;

  // Write-side flag and next-state: advance pointer on accepted push, shift read pointer sync chain
  always_comb begin
    write_valid_o = (wgray_q != (rsync_q[SyncStages-1] ^ FullMask));
    push          = write_req_i && write_valid_o;
    wbin_d        = wbin_q + PtrW'(push);
    wgray_d       = bin2gray(wbin_d);
    rsync_d       = {rsync_q[SyncStages-2:0], rgray_q};
  end

  // Write-domain registers
  always_ff @(posedge write_clk_i or posedge write_rst_i) begin
    if (write_rst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rsync_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rsync_q <= rsync_d;
    end
  end

  // Storage array, written on accepted push; deliberately not reset
  always_ff @(posedge write_clk_i) begin
    if (push) begin
      mem_q[wbin_q[AddrW-1:0]] <= data_i;
    end
  end

  // Read-side flag and next-state: advance pointer and capture data on accepted pop
  always_comb begin
    read_valid_o = (rgray_q != wsync_q[SyncStages-1]);
    pop          = read_req_i && read_valid_o;
    rbin_d       = rbin_q + PtrW'(pop);
    rgray_d      = bin2gray(rbin_d);
    wsync_d      = {wsync_q[SyncStages-2:0], wgray_q};
    data_d       = pop ? mem_q[rbin_q[AddrW-1:0]] : data_q;
  end

  // Read-domain registers
  always_ff @(posedge read_clk_i or posedge read_rst_i) begin
    if (read_rst_i) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      wsync_q <= '0;
      data_q  <= '0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      wsync_q <= wsync_d;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_cdc_fifo.sv
// Scoreboard bench for cdc_fifo: stimulus queues expected pop data, a
// separate monitor compares data_o after every accepted pop.
module tb_cdc_fifo;

  localparam int unsigned Size       = 16;
  localparam int unsigned Width      = 8;
  localparam int unsigned SyncStages = 2;

  logic             clk;
  logic             rst;
  logic             write_req_i;
  logic             write_valid_o;
  logic             read_req_i;
  logic             read_valid_o;
  logic [Width-1:0] data_i;
  logic [Width-1:0] data_o;

  int tests;
  int fails;

  logic [Width-1:0] model_q[$];  // data the bench expects the FIFO to hold
  logic [Width-1:0] exp_q[$];    // expected data_o for each issued pop

  cdc_fifo #(
    .Size       (Size),
    .Width      (Width),
    .SyncStages (SyncStages)
  ) dut (
    .read_clk_i    (clk),
    .read_rst_i    (rst),
    .write_clk_i   (clk),
    .write_rst_i   (rst),
    .write_req_i   (write_req_i),
    .write_valid_o (write_valid_o),
    .read_req_i    (read_req_i),
    .read_valid_o  (read_valid_o),
    .data_i        (data_i),
    .data_o        (data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push(input logic [Width-1:0] d, input bit exp_accept);
    write_req_i = 1'b1;
    data_i      = d;
    if (exp_accept) model_q.push_back(d);
    cyc();
    write_req_i = 1'b0;
  endtask

  task automatic pop();
    read_req_i = 1'b1;
    if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
    cyc();
    read_req_i = 1'b0;
  endtask

  // Monitor: sample handshake mid-cycle, compare data_o just after the edge
  initial begin : monitor
    bit fire;
    logic [Width-1:0] exp;
    forever begin
      @(negedge clk);
      fire = read_req_i && read_valid_o && !rst;
      @(posedge clk);
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got data 0x%0h expected no pop at %0t", data_o, $time);
        end else begin
          exp = exp_q.pop_front();
          check("pop_data", 32'(data_o), 32'(exp));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen;
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    write_req_i = 1'b0;
    read_req_i  = 1'b0;
    data_i      = '0;

    // Reset held for 100 cycles
    wait_cycles(100);
    check("rst_held_rv", 32'(read_valid_o), 0);
    check("rst_held_wv", 32'(write_valid_o), 1);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    check("rst_rv", 32'(read_valid_o), 0);
    check("rst_wv", 32'(write_valid_o), 1);
    check("rst_data", 32'(data_o), 0);

    // Single push / pop
    push(8'hAB, 1'b1);
    wait_cycles(3);
    check("one_wv", 32'(write_valid_o), 1);
    check("one_rv", 32'(read_valid_o), 1);
    pop();
    check("one_rv_after_pop", 32'(read_valid_o), 0);
    check("one_wv_after_pop", 32'(write_valid_o), 1);
    wait_cycles(3);

    // Fill to full with 0x00..0x0F back-to-back
    for (int i = 0; i < 16; i++) begin
      check("fill_wv_before", 32'(write_valid_o), 1);
      push(8'(i), 1'b1);
    end
    check("full_wv", 32'(write_valid_o), 0);
    check("full_rv", 32'(read_valid_o), 1);
    push(8'hFF, 1'b0);
    check("full_ignored_wv", 32'(write_valid_o), 0);
    wait_cycles(3);

    // Drain 16 back-to-back
    read_req_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_rv_before", 32'(read_valid_o), 1);
      if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
      cyc();
    end
    read_req_i = 1'b0;
    check("empty_rv", 32'(read_valid_o), 0);
    seen = 1'b0;
    for (int i = 0; i <= int'(SyncStages) + 1 && !seen; i++) begin
      if (write_valid_o) seen = 1'b1;
      else cyc();
    end
    check("empty_wv_recovers", 32'(seen), 1);

    // Interleaved push/pop pairs across pointer wrap
    for (int i = 0; i < 40; i++) begin
      push(8'(8'h20 + i), 1'b1);
      wait_cycles(3);
      pop();
    end
    wait_cycles(3);
    check("wrap_empty_rv", 32'(read_valid_o), 0);

    // Simultaneous push+pop with one entry resident
    push(8'h80, 1'b1);
    wait_cycles(3);
    for (int i = 1; i <= 5; i++) begin
      check("simul_rv", 32'(read_valid_o), 1);
      check("simul_wv", 32'(write_valid_o), 1);
      write_req_i = 1'b1;
      read_req_i  = 1'b1;
      data_i      = 8'(8'h80 + i);
      exp_q.push_back(model_q.pop_front());
      model_q.push_back(8'(8'h80 + i));
      cyc();
      write_req_i = 1'b0;
      read_req_i  = 1'b0;
      wait_cycles(3);
    end
    check("simul_occ_rv", 32'(read_valid_o), 1);
    pop();
    wait_cycles(3);
    check("simul_final_rv", 32'(read_valid_o), 0);

    // Reset mid-operation with 5 entries resident
    for (int i = 0; i < 6; i++) push(8'(8'h11 + i), 1'b1);
    wait_cycles(3);
    pop();
    wait_cycles(2);
    check("pre_rst_rv", 32'(read_valid_o), 1);
    #2;
    rst = 1'b1;
    model_q.delete();
    #1;
    check("async_rst_rv", 32'(read_valid_o), 0);
    check("async_rst_wv", 32'(write_valid_o), 1);
    check("async_rst_data", 32'(data_o), 0);
    wait_cycles(3);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    check("post_rst_rv", 32'(read_valid_o), 0);
    push(8'h5A, 1'b1);
    wait_cycles(3);
    pop();
    wait_cycles(3);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdc_fifo.md
Name: cdc_fifo

Overview:
- Dual-pointer asynchronous-style FIFO with Gray-coded pointers.
- Pointers cross between the write and read domains through configurable synchronizer chains.
- Sits at block boundaries as a generic elastic buffer; write side signals space available, read side signals data available.
- Clocking: one clock. read_clk_i and write_clk_i are both driven by that single clock. Reset is asynchronous and active-high; read_rst_i and write_rst_i are both driven by that single reset. The synchronizer structure is nevertheless implemented in full, as for independent clocks.

Parameters:
- Size, 16, entry count; power of two, >= 2; all Size entries usable.
- Width, 8, data width in bits.
- SyncStages, 2, flops per pointer synchronizer chain; >= 2.

Ports:
- read_clk_i  input  1  read-domain clock (same clock as write_clk_i)
- read_rst_i  input  1  asynchronous active-high reset, read domain
- write_clk_i  input  1  write-domain clock
- write_rst_i  input  1  asynchronous active-high reset, write domain
- write_req_i  input  1  push request, sampled on write_clk_i rising edge
- write_valid_o  output  1  FIFO not full; push accepted when high
- read_req_i  input  1  pop request, sampled on read_clk_i rising edge
- read_valid_o  output  1  FIFO not empty; pop accepted when high
- data_i  input  Width  push data
- data_o  output  Width  registered pop data

Behaviour:
- Pointers: write and read pointers are log2(Size)+1 bits, binary internally, with a registered Gray copy. The extra MSB distinguishes full from empty.
- Storage: Size x Width register array, not reset.
- Push: on write_clk_i rising edge with write_req_i && write_valid_o:
  - mem[wptr[log2(Size)-1:0]] <= data_i;
  - wptr increments, wrapping naturally mod 2*Size.
  - A push with write_valid_o low is ignored, with no state change.
- Pop: on read_clk_i rising edge with read_req_i && read_valid_o:
  - data_o <= mem[rptr index];
  - rptr increments.
  - data_o is valid from that edge, i.e. one cycle of latency, and holds until the next accepted pop.
  - A pop with read_valid_o low is ignored; data_o holds.
- Synchronization:
  - Gray wptr passes through SyncStages flops clocked by read_clk_i, reset by read_rst_i.
  - Gray rptr passes through SyncStages flops clocked by write_clk_i, reset by write_rst_i.
- Flag computation:
  - write_valid_o = !(wgray == {~rsync[MSB:MSB-1], rsync[rest]}), computed combinationally from the local registered pointer and the synchronized remote pointer.
  - read_valid_o = (rgray != wsync).
  - Full and empty therefore assert immediately, in the same cycle the local pointer updates.
  - Deassertion is pessimistic: read_valid_o rises at most SyncStages+1 read edges after a push; write_valid_o rises at most SyncStages+1 write edges after a pop.
- Simultaneous push and pop in the same cycle: both are performed independently whenever their respective valid flags are high.
- Wrap-around: pointers wrap modulo 2*Size. Indices wrap modulo Size without a gap or loss of ordering.
- Reset, asserted asynchronously, including mid-operation:
  - Domain pointers, Gray registers and sync chains clear to 0.
  - data_o clears to 0.
  - write_valid_o = 1 and read_valid_o = 0 while reset is held and after release.
  - All FIFO contents are discarded.
  - Both resets are asserted together.
- Ordering: strict FIFO; no data duplication or loss.

Test Plan:
- Hold reset 100 cycles, then release -> read_valid_o=0, write_valid_o=1, data_o=0.
- Push 0xAB, wait 3 cycles -> write_valid_o=1 and read_valid_o=1. Pop (req high for one edge) -> data_o=0xAB on the following cycle; read_valid_o=0 immediately after; write_valid_o=1.
- Push 0x00..0x0F on 16 back-to-back cycles -> write_valid_o=1 before each push and 0 right after the 16th; read_valid_o=1. A 17th push with 0xFF is ignored.
- Pop 16 times -> data_o returns 0x00..0x0F in order; read_valid_o=0 right after the 16th pop; write_valid_o=1 within SyncStages+1 cycles.
- Wrap test: 40 interleaved push/pop pairs with incrementing data, plus simultaneous push+pop with one entry resident -> data returned in order across pointer wrap; occupancy unchanged by simultaneous ops.
- Assert reset with 5 entries stored -> read_valid_o=0, write_valid_o=1, data_o=0 asynchronously. After release, a push of 0x5A followed by a pop returns 0x5A.
